// File: rtl/fir_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_pkg                                                                    |
// | Shared types and helpers for the fir_mac_bank FIR filter.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_t;

    localparam int RED_W = 64;

    function automatic int tap_idx_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    // Narrowing of the shifted accumulator: clamp when sat is set, otherwise the
    // caller keeps the low data_w bits (two's-complement wrap).
    function automatic logic signed [RED_W-1:0] fir_reduce(
        input logic signed [RED_W-1:0] v,
        input int                      data_w,
        input bit                      sat
    );
        logic signed [RED_W-1:0] hi;
        logic signed [RED_W-1:0] lo;
        hi = $signed((64'd1 << (data_w - 1)) - 64'd1);
        lo = -$signed(64'd1 << (data_w - 1));
        if (sat && (v > hi)) return hi;
        if (sat && (v < lo)) return lo;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coeff_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_coeff_bank                                                             |
// | Active/shadow coefficient store with sample-boundary bank swap.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_coeff_bank
    import fir_pkg::*;
#(
    parameter int TAPS    = 64,
    parameter int COEFF_W = 10,
    parameter int IDX_W   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic [IDX_W-1:0]          waddr,
    input  logic signed [COEFF_W-1:0] wdata,
    input  logic                      swap_req,
    input  logic                      accept,
    input  logic [IDX_W-1:0]          raddr,
    output logic signed [COEFF_W-1:0] rdata,
    output logic                      swap_ack
);

    logic signed [COEFF_W-1:0] r_bank [2][TAPS];
    logic                      r_sel;
    logic                      r_pending;
    logic                      r_ack;
    logic                      w_do_swap;

    assign w_do_swap = accept && r_pending;

    // Writes target the bank that is shadow before this edge, so a write
    // coincident with a swap ends up in the newly active bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int t = 0; t < TAPS; t++) begin
                    r_bank[b][t] <= '0;
                end
            end
            r_sel     <= 1'b0;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            if (we) begin
                r_bank[~r_sel][waddr] <= wdata;
            end
            if (w_do_swap) begin
                r_sel <= ~r_sel;
            end
            r_ack     <= w_do_swap;
            r_pending <= (r_pending && !w_do_swap) || swap_req;
        end
    end

    assign rdata    = r_bank[r_sel][raddr];
    assign swap_ack = r_ack;

endmodule
`default_nettype wire

// File: rtl/fir_mac_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fir_mac_bank                                                               |
// | Single-MAC FIR with circular history and double-buffered coefficients.     |
// | Define FIR_SAT_EN to saturate the output instead of wrapping it.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fir_mac_bank
    import fir_pkg::*;
#(
    parameter int TAPS    = 64,
    parameter int DATA_W  = 16,
    parameter int COEFF_W = 10,
    parameter int ACC_W   = DATA_W + COEFF_W + $clog2(TAPS),
    parameter int SHIFT   = 10
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       ready_in,
    input  logic signed [DATA_W-1:0]   signal_in,
    input  logic                       coeff_we_in,
    input  logic [$clog2(TAPS)-1:0]    coeff_addr_in,
    input  logic signed [COEFF_W-1:0]  coeff_data_in,
    input  logic                       coeff_swap_in,
    output logic signed [DATA_W-1:0]   signal_out,
    output logic                       done_out,
    output logic                       busy_out,
    output logic                       swap_ack_out,
    output logic                       overrun_out
);

    localparam int               IDX_W  = tap_idx_w(TAPS);
    localparam int               PROD_W = DATA_W + COEFF_W;
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(TAPS - 1);
`ifdef FIR_SAT_EN
    localparam bit               SAT_EN = 1'b1;
`else
    localparam bit               SAT_EN = 1'b0;
`endif

    fir_state_t                r_state;
    fir_state_t                w_state_next;
    logic signed [DATA_W-1:0]  r_hist [TAPS];
    logic [IDX_W-1:0]          r_wr_ptr;
    logic [IDX_W-1:0]          r_newest;
    logic [IDX_W-1:0]          r_k;
    logic [IDX_W-1:0]          w_hidx;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W-1:0]   w_shifted;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [COEFF_W-1:0] w_coeff;
    logic signed [DATA_W-1:0]  w_sample;
    logic signed [RED_W-1:0]   w_red;
    logic signed [DATA_W-1:0]  r_out;
    logic                      r_done;
    logic                      r_overrun;
    logic                      w_accept;
    logic                      w_unused_red;

    assign w_accept = (r_state == IDLE) && ready_in;

    fir_coeff_bank #(
        .TAPS    (TAPS),
        .COEFF_W (COEFF_W),
        .IDX_W   (IDX_W)
    ) u_coeff_bank (
        .clk      (clk_in),
        .rst      (rst_in),
        .we       (coeff_we_in),
        .waddr    (coeff_addr_in),
        .wdata    (coeff_data_in),
        .swap_req (coeff_swap_in),
        .accept   (w_accept),
        .raddr    (r_k),
        .rdata    (w_coeff),
        .swap_ack (swap_ack_out)
    );

    // Tap k pairs with the sample k positions older than the newest one.
    assign w_hidx       = r_newest - r_k;
    assign w_sample     = r_hist[w_hidx];
    assign w_prod       = PROD_W'(w_coeff) * PROD_W'(w_sample);
    assign w_prod_ext   = ACC_W'(w_prod);
    assign w_acc_next   = r_acc + w_prod_ext;
    assign w_shifted    = w_acc_next >>> SHIFT;
    assign w_red        = fir_reduce(RED_W'(w_shifted), DATA_W, SAT_EN);
    assign w_unused_red = &{1'b0, w_red[RED_W-1:DATA_W]};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (ready_in) w_state_next = MAC;
            MAC:     if (r_k == K_LAST) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < TAPS; i++) begin
                r_hist[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_newest  <= '0;
            r_k       <= '0;
            r_acc     <= '0;
            r_out     <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_overrun <= ready_in && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (ready_in) begin
                        r_hist[r_wr_ptr] <= signal_in;
                        r_newest         <= r_wr_ptr;
                        r_wr_ptr         <= r_wr_ptr + 1'b1;
                        r_acc            <= '0;
                        r_k              <= '0;
                    end
                end
                MAC: begin
                    r_acc <= w_acc_next;
                    r_k   <= r_k + 1'b1;
                    // Final product is folded in here so the result is ready in DONE.
                    if (r_k == K_LAST) begin
                        r_out  <= w_red[DATA_W-1:0];
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign signal_out  = r_out;
    assign done_out    = r_done;
    assign busy_out    = (r_state != IDLE);
    assign overrun_out = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fir_mac_bank                                                            |
// | Directed self-checking bench for fir_mac_bank (SHIFT = 0).                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fir_mac_bank;

    localparam int TAPS    = 64;
    localparam int DATA_W  = 16;
    localparam int COEFF_W = 10;
    localparam int SHIFT   = 0;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      ready;
    logic signed [DATA_W-1:0]  sig;
    logic                      we;
    logic [5:0]                addr;
    logic signed [COEFF_W-1:0] cdata;
    logic                      swap;
    logic signed [DATA_W-1:0]  sig_out;
    logic                      done;
    logic                      busy;
    logic                      ack;
    logic                      ovr;

    fir_mac_bank #(
        .TAPS    (TAPS),
        .DATA_W  (DATA_W),
        .COEFF_W (COEFF_W),
        .SHIFT   (SHIFT)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .ready_in      (ready),
        .signal_in     (sig),
        .coeff_we_in   (we),
        .coeff_addr_in (addr),
        .coeff_data_in (cdata),
        .coeff_swap_in (swap),
        .signal_out    (sig_out),
        .done_out      (done),
        .busy_out      (busy),
        .swap_ack_out  (ack),
        .overrun_out   (ovr)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;

    logic signed [COEFF_W-1:0] m_bank [2][TAPS];
    logic signed [DATA_W-1:0]  m_hist [TAPS];
    bit                        m_sel;
    bit                        m_pending;
    int                        m_wr;
    int                        m_newest;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic model_reset();
        for (int t = 0; t < TAPS; t++) begin
            m_bank[0][t] = '0;
            m_bank[1][t] = '0;
            m_hist[t]    = '0;
        end
        m_sel     = 1'b0;
        m_pending = 1'b0;
        m_wr      = 0;
        m_newest  = 0;
    endtask

    function automatic logic signed [DATA_W-1:0] model_out();
        longint acc;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            acc += longint'(m_bank[m_sel][k]) * longint'(m_hist[(m_newest - k) & (TAPS - 1)]);
        end
        acc = acc >>> SHIFT;
`ifdef FIR_SAT_EN
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
`endif
        return acc[DATA_W-1:0];
    endfunction

    task automatic write_coeff(input int a, input logic signed [COEFF_W-1:0] d);
        addr  = 6'(a);
        cdata = d;
        we    = 1'b1;
        step();
        we = 1'b0;
        m_bank[~m_sel][a] = d;
    endtask

    task automatic swap_pulse();
        swap = 1'b1;
        step();
        swap = 1'b0;
        m_pending = 1'b1;
    endtask

    // Feeds one sample and follows it to done_out; optional swap / extra ready
    // pulses are injected at the given cycle numbers (cycle 0 = accept).
    task automatic send(input logic signed [DATA_W-1:0] s, input int swap_at, input int ovr_at,
                        output logic signed [DATA_W-1:0] out);
        logic signed [DATA_W-1:0] expv;
        int cyc;
        int done_cyc;
        ready = 1'b1;
        sig   = s;
        step();
        ready = 1'b0;
        chk("swap_ack", 64'(ack), 64'(m_pending));
        if (m_pending) begin
            m_sel     = ~m_sel;
            m_pending = 1'b0;
        end
        m_hist[m_wr] = s;
        m_newest     = m_wr;
        m_wr         = (m_wr + 1) % TAPS;
        expv         = model_out();
        cyc          = 1;
        done_cyc     = -1;
        while (done_cyc < 0 && cyc <= TAPS + 20) begin
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (cyc == 2) chk("busy_mac", 64'(busy), 64'd1);
                if (cyc == swap_at) swap = 1'b1;
                if (cyc == ovr_at) begin
                    ready = 1'b1;
                    sig   = 16'sh1234;
                end
                step();
                if (cyc == swap_at) m_pending = 1'b1;
                swap  = 1'b0;
                ready = 1'b0;
                cyc++;
                if (ovr_at > 0 && cyc == ovr_at + 1) chk("overrun", 64'(ovr), 64'd1);
            end
        end
        chk("latency", 64'(done_cyc), 64'(TAPS + 1));
        chk("out_model", 64'(sig_out), 64'(expv));
        out = sig_out;
        step();
        chk("done_pulse", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("out_held", 64'(sig_out), 64'(expv));
    endtask

    initial begin
        logic signed [DATA_W-1:0]  o;
        logic signed [COEFF_W-1:0] cr;
        int dones;

        rst = 1'b1; ready = 1'b0; sig = '0; we = 1'b0; addr = '0; cdata = '0; swap = 1'b0;
        model_reset();
        repeat (3) step();
        chk("rst_out", 64'(sig_out), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_ovr", 64'(ovr), 64'd0);
        rst = 1'b0;
        step();

        // Impulse through coefficients k[i] = i
        for (int i = 0; i < TAPS; i++) write_coeff(i, 10'(i));
        swap_pulse();
        for (int i = 0; i <= TAPS; i++) begin
            send((i == 0) ? 16'sd1 : 16'sd0, -1, -1, o);
            chk("impulse", 64'(o), (i < TAPS) ? 64'(i) : 64'd0);
        end

        // Shadow = 2*i, swap requested mid-MAC and again before acceptance
        for (int i = 0; i < TAPS; i++) write_coeff(i, 10'(2 * i));
        send(16'sd1, -1, -1, o);
        chk("swap_pre", 64'(o), 64'd0);
        send(16'sd0, 10, -1, o);
        chk("swap_old_taps", 64'(o), 64'd1);
        swap_pulse();
        for (int i = 2; i < TAPS; i++) begin
            send(16'sd0, -1, -1, o);
            chk("swap_new_taps", 64'(o), 64'(2 * i));
        end

        // Overrun: second ready at cycle 5 is dropped
        send(16'sd100, -1, 5, o);
        send(16'sd0, -1, -1, o);
        chk("overrun_next", 64'(o), 64'd200);
        send(16'sd0, -1, -1, o);
        chk("overrun_next2", 64'(o), 64'd400);

        // Full-scale width
        for (int i = 0; i < TAPS; i++) write_coeff(i, 10'sd511);
        swap_pulse();
        for (int i = 0; i < TAPS; i++) send(16'sd32767, -1, -1, o);
`ifdef FIR_SAT_EN
        chk("width_pos", 64'(o), 64'd32767);
`else
        chk("width_pos", 64'(o), -64'sd32704);
`endif
        for (int i = 0; i < TAPS; i++) send(-16'sd32768, -1, -1, o);
`ifdef FIR_SAT_EN
        chk("width_neg", 64'(o), -64'sd32768);
`else
        chk("width_neg", 64'(o), 64'd0);
`endif

        // Random samples and coefficients, crossing the history wrap
        for (int i = 0; i < TAPS; i++) begin
            cr = 10'($urandom);
            write_coeff(i, cr);
        end
        swap_pulse();
        for (int n = 0; n < 200; n++) begin
            if (n == 100) begin
                for (int i = 0; i < TAPS; i++) begin
                    cr = 10'($urandom);
                    write_coeff(i, cr);
                end
                swap_pulse();
            end
            send(16'($urandom), -1, -1, o);
        end

        // Reset in the middle of a computation
        ready = 1'b1;
        sig   = 16'sd7;
        step();
        ready = 1'b0;
        repeat (29) step();
        chk("busy_pre_rst", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_out", 64'(sig_out), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ack", 64'(ack), 64'd0);
        chk("midrst_ovr", 64'(ovr), 64'd0);
        model_reset();
        dones = 0;
        for (int c = 0; c < TAPS + 10; c++) begin
            if (done) dones++;
            step();
        end
        chk("no_done_after_rst", 64'(dones), 64'd0);
        send(16'sd1, -1, -1, o);
        chk("zero_after_rst", 64'(o), 64'd0);
        swap_pulse();
        send(16'sd0, -1, -1, o);
        chk("zero_shadow_after_rst", 64'(o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
